// File: rtl/spart_rx_fifo_pkg.sv
// Shared SPART definitions: RX deframer state encodings and baud divisor constants.
// The RX FSM uses RX_PARITY only when SPART_RX_PARITY_EN is defined.
package spart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int SYS_CLK_HZ     = 50_000_000;

  // Rounded clk cycles per baud_en strobe; the baud generator and tx use the same table.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  localparam int BAUD_DIV_9600   = baud_div(SYS_CLK_HZ, 9600,   DEF_OVERSAMPLE);
  localparam int BAUD_DIV_19200  = baud_div(SYS_CLK_HZ, 19200,  DEF_OVERSAMPLE);
  localparam int BAUD_DIV_38400  = baud_div(SYS_CLK_HZ, 38400,  DEF_OVERSAMPLE);
  localparam int BAUD_DIV_115200 = baud_div(SYS_CLK_HZ, 115200, DEF_OVERSAMPLE);

endpackage

// File: rtl/spart_rx_fifo_if.sv
// Bus-side view of the SPART receiver: pop/clear controls, FIFO head, status flags.
// SPART_RX_PARITY_EN adds parity_odd / parity_err.
interface spart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 rd_rx;
  logic                 clr_err;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic [CW-1:0]        rx_count;
  logic                 frame_err;
  logic                 overrun;
`ifdef SPART_RX_PARITY_EN
  logic                 parity_odd;
  logic                 parity_err;

  modport master (output rd_rx, clr_err, parity_odd,
                  input  rx_data, rda, rx_count, frame_err, overrun, parity_err);
  modport slave  (input  rd_rx, clr_err, parity_odd,
                  output rx_data, rda, rx_count, frame_err, overrun, parity_err);
`else
  modport master (output rd_rx, clr_err,
                  input  rx_data, rda, rx_count, frame_err, overrun);
  modport slave  (input  rd_rx, clr_err,
                  output rx_data, rda, rx_count, frame_err, overrun);
`endif

endinterface

// File: rtl/spart_rx_fifo_fifo.sv
// Show-ahead synchronous FIFO: head is visible combinationally, zero when empty.
// A push into a full FIFO only lands if a pop retires the head in the same cycle.
module spart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: 2-FF synchronised, oversampled deframer feeding a show-ahead RX FIFO.
// Define SPART_RX_PARITY_EN to add a parity bit between data and stop.
module spart_rx_fifo
  import spart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_en,
  input  logic           rxd,
  spart_rx_fifo_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_T = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_T = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

  rx_state_e            state;
  logic                 rxd_s1, rxd_s2;
  logic                 armed;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_q;
  logic                 fifo_drop;
  logic                 fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // shreg holds the completed byte as the FIFO write data; it is not disturbed
  // until the next frame's first data sample, long after push_q has fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      armed     <= 1'b0;
      tick      <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      bus.frame_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (bus.clr_err) begin
        bus.frame_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
        bus.parity_err <= 1'b0;
`endif
      end
      if (baud_en) begin
        unique case (state)
          RX_IDLE: begin
            // A start edge counts only after the line has been seen idle.
            if (!armed) armed <= rxd_s2;
            else if (!rxd_s2) begin
              state <= RX_START;
              tick  <= '0;
              armed <= 1'b0;
            end
          end
          RX_START: begin
            if (tick == HALF_T) begin
              tick   <= '0;
              bitcnt <= '0;
              state  <= rxd_s2 ? RX_IDLE : RX_DATA;
            end else tick <= tick + 1'b1;
          end
          RX_DATA: begin
            if (tick == FULL_T) begin
              tick   <= '0;
              shreg  <= {rxd_s2, shreg[DATA_BITS-1:1]};
              bitcnt <= bitcnt + 1'b1;
`ifdef SPART_RX_PARITY_EN
              if (bitcnt == LAST_B) state <= RX_PARITY;
`else
              if (bitcnt == LAST_B) state <= RX_STOP;
`endif
            end else tick <= tick + 1'b1;
          end
`ifdef SPART_RX_PARITY_EN
          RX_PARITY: begin
            if (tick == FULL_T) begin
              tick  <= '0;
              state <= RX_STOP;
              if (((^shreg) ^ rxd_s2) != bus.parity_odd) bus.parity_err <= 1'b1;
            end else tick <= tick + 1'b1;
          end
`endif
          RX_STOP: begin
            if (tick == FULL_T) begin
              tick  <= '0;
              state <= RX_IDLE;
              if (rxd_s2) push_q <= 1'b1;
              else        bus.frame_err <= 1'b1;
            end else tick <= tick + 1'b1;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bus.overrun <= 1'b0;
    else     bus.overrun <= (bus.overrun && !bus.clr_err) || fifo_drop;
  end

  spart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (shreg),
    .pop   (bus.rd_rx),
    .rdata (bus.rx_data),
    .count (bus.rx_count),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign bus.rda = !fifo_empty;

endmodule
